// File: rtl/accel_bcd_converter.sv
// Accelerometer X/Y averaging and sign + 3-digit BCD conversion.
// Samples the latched axis bytes every SAMPLE_DIV cycles, averages
// 2^AVG_LOG2 samples per axis, then runs a 10-step double-dabble on
// both axes in parallel before publishing to the display driver.
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_ACCUM   | summing samples on capture edges
// ST_CALC    | average, sign/magnitude split, load dabble registers
// ST_DABBLE  | 10 double-dabble iterations, one bit per cycle
// ST_PUBLISH | register outputs, pulse oVALID
module accel_bcd_converter #(
    parameter int SAMPLE_DIV = 50000,
    parameter int AVG_LOG2   = 2
) (
    input  logic        iSPI_CLK,
    input  logic        iRSTN,
    input  logic [7:0]  iDATA_L,
    input  logic [7:0]  iDATA_H,
    input  logic [7:0]  iDATA_Y_L,
    input  logic [7:0]  iDATA_Y_H,
    output logic        oX_SIGN,
    output logic [11:0] oX_BCD,
    output logic        oY_SIGN,
    output logic [11:0] oY_BCD,
    output logic        oVALID
);

    localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int AW = 10 + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(2 ** AVG_LOG2);

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_CALC    = 2'd1;
    localparam logic [1:0] ST_DABBLE  = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    logic [1:0]           state;
    logic [TW-1:0]        timer;
    logic                 capture;
    logic [CW-1:0]        cnt;
    logic signed [AW-1:0] acc_x, acc_y;
    logic [9:0]           x_raw, y_raw;
    logic signed [AW-1:0] x_ext, y_ext;
    logic signed [AW-1:0] x_shift, y_shift;
    logic [9:0]           x_avg, y_avg;
    logic [9:0]           x_mag, y_mag;
    logic [21:0]          dd_x, dd_y;
    logic                 sign_x, sign_y;
    logic [3:0]           dd_cnt;
    logic                 unused_bits;

    // One double-dabble iteration: BCD field sits above the 10-bit binary field.
    function automatic logic [21:0] dd_step(input logic [21:0] r);
        logic [21:0] t;
        t = r;
        for (int n = 0; n < 3; n++) begin
            if (t[10+4*n +: 4] >= 4'd5)
                t[10+4*n +: 4] = t[10+4*n +: 4] + 4'd3;
        end
        return {t[20:0], 1'b0};
    endfunction

    // Sample decode, window average and magnitude, all combinational.
    always_comb begin
        x_raw   = {iDATA_H[1:0], iDATA_L};
        y_raw   = {iDATA_Y_H[1:0], iDATA_Y_L};
        x_ext   = AW'($signed(x_raw));
        y_ext   = AW'($signed(y_raw));
        x_shift = acc_x >>> AVG_LOG2;
        y_shift = acc_y >>> AVG_LOG2;
        x_avg   = x_shift[9:0];
        y_avg   = y_shift[9:0];
        x_mag   = x_avg[9] ? (~x_avg + 10'd1) : x_avg;
        y_mag   = y_avg[9] ? (~y_avg + 10'd1) : y_avg;
        capture = (timer == TW'(SAMPLE_DIV - 1));
    end

    // Upper bits of the bytes and shifted sums are intentionally unused.
    assign unused_bits = ^{iDATA_H[7:2], iDATA_Y_H[7:2], x_shift, y_shift};

    // Free-running sample timer, independent of the FSM.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN)
            timer <= '0;
        else if (capture)
            timer <= '0;
        else
            timer <= timer + TW'(1);
    end

    // Accumulate / convert / publish sequencer.
    always_ff @(posedge iSPI_CLK or negedge iRSTN) begin
        if (!iRSTN) begin
            state   <= ST_ACCUM;
            cnt     <= '0;
            acc_x   <= '0;
            acc_y   <= '0;
            dd_x    <= '0;
            dd_y    <= '0;
            sign_x  <= 1'b0;
            sign_y  <= 1'b0;
            dd_cnt  <= '0;
            oX_SIGN <= 1'b0;
            oX_BCD  <= '0;
            oY_SIGN <= 1'b0;
            oY_BCD  <= '0;
            oVALID  <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            case (state)
                ST_ACCUM: begin
                    if (capture) begin
                        acc_x <= acc_x + x_ext;
                        acc_y <= acc_y + y_ext;
                        cnt   <= cnt + CW'(1);
                        if (cnt + CW'(1) == CNT_FULL)
                            state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    dd_x   <= {12'd0, x_mag};
                    dd_y   <= {12'd0, y_mag};
                    // A zero magnitude never carries a sign.
                    sign_x <= x_avg[9] & (|x_mag);
                    sign_y <= y_avg[9] & (|y_mag);
                    acc_x  <= '0;
                    acc_y  <= '0;
                    cnt    <= '0;
                    dd_cnt <= '0;
                    state  <= ST_DABBLE;
                end
                ST_DABBLE: begin
                    dd_x   <= dd_step(dd_x);
                    dd_y   <= dd_step(dd_y);
                    dd_cnt <= dd_cnt + 4'd1;
                    if (dd_cnt == 4'd9)
                        state <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    oX_SIGN <= sign_x;
                    oX_BCD  <= dd_x[21:10];
                    oY_SIGN <= sign_y;
                    oY_BCD  <= dd_y[21:10];
                    oVALID  <= 1'b1;
                    state   <= ST_ACCUM;
                end
                default: state <= ST_ACCUM;
            endcase
        end
    end

endmodule
